// File: rtl/control_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : control_unit_if                                            |
// | Brief    : Instruction/status inputs and datapath strobes between    |
// |            the datapath (master) and the control unit (slave).       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface control_unit_if;
  logic [4:0] OPCODE;
  logic [2:0] STATUS_SEL;
  logic [7:0] STATUS;
  logic [3:0] ALU_OPERATION;
  logic       INC_PROGCOUNT;
  logic       CLR_PROGCOUNT;
  logic       WRITE_PROGCOUNT;
  logic       READ_PROGCOUNT;
  logic       WRITE_INSTREG;
  logic       WRITE_REGS;
  logic       USE_IMMEDIATE;
  logic       USE_DISPLACEMENT;
  logic       WRITE_MEM;
  logic       READ_MEM;
  logic       WRITE_MEMADDR;
  logic       WRITE_STATREG;
  logic       CLR_STATBIT;
  logic       SET_STATBIT;
  logic       PRESET_STACKPTR;
  logic       INC_STACKPTR;
  logic       DEC_STACKPTR;
  logic       READ_STACKPTR;
  logic       HALTED;

  // Datapath side: supplies the instruction fields and status, consumes strobes
  modport master (
    output OPCODE, STATUS_SEL, STATUS,
    input  ALU_OPERATION, INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT,
           READ_PROGCOUNT, WRITE_INSTREG, WRITE_REGS, USE_IMMEDIATE,
           USE_DISPLACEMENT, WRITE_MEM, READ_MEM, WRITE_MEMADDR, WRITE_STATREG,
           CLR_STATBIT, SET_STATBIT, PRESET_STACKPTR, INC_STACKPTR,
           DEC_STACKPTR, READ_STACKPTR, HALTED
  );

  // Control unit side
  modport slave (
    input  OPCODE, STATUS_SEL, STATUS,
    output ALU_OPERATION, INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT,
           READ_PROGCOUNT, WRITE_INSTREG, WRITE_REGS, USE_IMMEDIATE,
           USE_DISPLACEMENT, WRITE_MEM, READ_MEM, WRITE_MEMADDR, WRITE_STATREG,
           CLR_STATBIT, SET_STATBIT, PRESET_STACKPTR, INC_STACKPTR,
           DEC_STACKPTR, READ_STACKPTR, HALTED
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : control_unit                                               |
// | Brief    : Instruction sequencer: INIT, FETCH, EX1..EX3, HALT.        |
// |            Strobes are decoded from the current step and OPCODE.     |
// |            Define YASAC_STACK_EN to enable CALL/RET/PUSH/POP; when   |
// |            undefined those opcodes run as NOP and the stack-pointer  |
// |            strobes are tied low.                                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module control_unit (
  input  logic          CLK,
  input  logic          RESET,
  control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EX1   = 3'd2,
    S_EX2   = 3'd3,
    S_EX3   = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [4:0] c_OP_HALT = 5'b00001;
  localparam logic [4:0] c_OP_LDI  = 5'b00010;
  localparam logic [4:0] c_OP_LD   = 5'b00011;
  localparam logic [4:0] c_OP_ST   = 5'b00100;
  localparam logic [4:0] c_OP_JMP  = 5'b00101;
  localparam logic [4:0] c_OP_BRS  = 5'b00110;
  localparam logic [4:0] c_OP_BRC  = 5'b00111;
  localparam logic [4:0] c_OP_CLRB = 5'b01000;
  localparam logic [4:0] c_OP_SETB = 5'b01001;
  localparam logic [4:0] c_OP_ALU  = 5'b1????;
`ifdef YASAC_STACK_EN
  localparam logic [4:0] c_OP_CALL = 5'b01010;
  localparam logic [4:0] c_OP_RET  = 5'b01011;
  localparam logic [4:0] c_OP_PUSH = 5'b01100;
  localparam logic [4:0] c_OP_POP  = 5'b01101;
`endif

  state_t r_state;

  // Step sequencer; multi-cycle instructions walk EX2/EX3 before refetching
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_INIT;
    end else begin
      case (r_state)
        S_INIT:  r_state <= S_FETCH;
        S_FETCH: r_state <= S_EX1;
        S_EX1: begin
          case (bus.OPCODE)
            c_OP_HALT:        r_state <= S_HALT;
            c_OP_LD, c_OP_ST: r_state <= S_EX2;
`ifdef YASAC_STACK_EN
            c_OP_CALL, c_OP_RET, c_OP_PUSH, c_OP_POP: r_state <= S_EX2;
`endif
            default:          r_state <= S_FETCH;
          endcase
        end
        S_EX2: begin
          case (bus.OPCODE)
`ifdef YASAC_STACK_EN
            c_OP_CALL, c_OP_RET, c_OP_POP: r_state <= S_EX3;
`endif
            default: r_state <= S_FETCH;
          endcase
        end
        S_EX3:   r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_INIT;
      endcase
    end
  end

  // Strobe decode. OPCODE comes straight from the instruction register,
  // which is loaded on the FETCH edge, so EX1 must decode it combinationally.
  always_comb begin
    bus.ALU_OPERATION    = 4'h0;
    bus.INC_PROGCOUNT    = 1'b0;
    bus.CLR_PROGCOUNT    = 1'b0;
    bus.WRITE_PROGCOUNT  = 1'b0;
    bus.READ_PROGCOUNT   = 1'b0;
    bus.WRITE_INSTREG    = 1'b0;
    bus.WRITE_REGS       = 1'b0;
    bus.USE_IMMEDIATE    = 1'b0;
    bus.USE_DISPLACEMENT = 1'b0;
    bus.WRITE_MEM        = 1'b0;
    bus.READ_MEM         = 1'b0;
    bus.WRITE_MEMADDR    = 1'b0;
    bus.WRITE_STATREG    = 1'b0;
    bus.CLR_STATBIT      = 1'b0;
    bus.SET_STATBIT      = 1'b0;
    bus.PRESET_STACKPTR  = 1'b0;
    bus.HALTED           = 1'b0;
`ifdef YASAC_STACK_EN
    bus.INC_STACKPTR     = 1'b0;
    bus.DEC_STACKPTR     = 1'b0;
    bus.READ_STACKPTR    = 1'b0;
`endif
    case (r_state)
      S_INIT: begin
        bus.CLR_PROGCOUNT   = 1'b1;
        bus.PRESET_STACKPTR = 1'b1;
      end
      S_FETCH: begin
        bus.WRITE_INSTREG = 1'b1;
        bus.INC_PROGCOUNT = 1'b1;
      end
      S_EX1: begin
        casez (bus.OPCODE)
          c_OP_LDI: begin
            bus.USE_IMMEDIATE = 1'b1;
            bus.WRITE_REGS    = 1'b1;
          end
          c_OP_LD, c_OP_ST: begin
            bus.USE_DISPLACEMENT = 1'b1;
            bus.ALU_OPERATION    = 4'h1;
            bus.WRITE_MEMADDR    = 1'b1;
          end
          c_OP_JMP: begin
            bus.USE_IMMEDIATE   = 1'b1;
            bus.WRITE_PROGCOUNT = 1'b1;
          end
          c_OP_BRS, c_OP_BRC: begin
            // BRS jumps on a set bit, BRC on a clear bit
            if (bus.STATUS[bus.STATUS_SEL] == (bus.OPCODE == c_OP_BRS)) begin
              bus.USE_IMMEDIATE   = 1'b1;
              bus.WRITE_PROGCOUNT = 1'b1;
            end
          end
          c_OP_CLRB: bus.CLR_STATBIT = 1'b1;
          c_OP_SETB: bus.SET_STATBIT = 1'b1;
          c_OP_ALU: begin
            bus.ALU_OPERATION = bus.OPCODE[3:0];
            bus.WRITE_REGS    = 1'b1;
            bus.WRITE_STATREG = 1'b1;
          end
`ifdef YASAC_STACK_EN
          c_OP_CALL, c_OP_PUSH: begin
            bus.READ_STACKPTR = 1'b1;
            bus.WRITE_MEMADDR = 1'b1;
          end
          c_OP_RET, c_OP_POP: bus.INC_STACKPTR = 1'b1;
`endif
          default: ;
        endcase
      end
      S_EX2: begin
        case (bus.OPCODE)
          c_OP_LD: begin
            bus.READ_MEM   = 1'b1;
            bus.WRITE_REGS = 1'b1;
          end
          c_OP_ST: begin
            bus.ALU_OPERATION = 4'h2;
            bus.WRITE_MEM     = 1'b1;
          end
`ifdef YASAC_STACK_EN
          c_OP_CALL: begin
            bus.READ_PROGCOUNT = 1'b1;
            bus.WRITE_MEM      = 1'b1;
            bus.DEC_STACKPTR   = 1'b1;
          end
          c_OP_PUSH: begin
            bus.ALU_OPERATION = 4'h2;
            bus.WRITE_MEM     = 1'b1;
            bus.DEC_STACKPTR  = 1'b1;
          end
          c_OP_RET, c_OP_POP: begin
            bus.READ_STACKPTR = 1'b1;
            bus.WRITE_MEMADDR = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      S_EX3: begin
`ifdef YASAC_STACK_EN
        case (bus.OPCODE)
          c_OP_CALL: begin
            bus.USE_IMMEDIATE   = 1'b1;
            bus.WRITE_PROGCOUNT = 1'b1;
          end
          c_OP_RET: begin
            bus.READ_MEM        = 1'b1;
            bus.WRITE_PROGCOUNT = 1'b1;
          end
          c_OP_POP: begin
            bus.READ_MEM   = 1'b1;
            bus.WRITE_REGS = 1'b1;
          end
          default: ;
        endcase
`endif
      end
      S_HALT:  bus.HALTED = 1'b1;
      default: ;
    endcase
  end

`ifndef YASAC_STACK_EN
  // Stack hardware absent: pointer strobes are held inactive
  assign bus.INC_STACKPTR  = 1'b0;
  assign bus.DEC_STACKPTR  = 1'b0;
  assign bus.READ_STACKPTR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_control_unit                                            |
// | Brief    : Directed bench for control_unit with a per-instruction    |
// |            micro-step model and a per-cycle compare process.         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_control_unit;

`ifdef YASAC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] alu;
    logic inc_pc, clr_pc, wr_pc, rd_pc, wr_ir, wr_regs, use_imm, use_disp;
    logic wr_mem, rd_mem, wr_ma, wr_sr, clr_sb, set_sb, preset_sp;
    logic inc_sp, dec_sp, rd_sp, halted;
  } outs_t;

  // Hand-computed vectors: alu[22:19] inc_pc18 clr_pc17 wr_pc16 rd_pc15
  // wr_ir14 wr_regs13 use_imm12 use_disp11 wr_mem10 rd_mem9 wr_ma8 wr_sr7
  // clr_sb6 set_sb5 preset_sp4 inc_sp3 dec_sp2 rd_sp1 halted0
  localparam logic [22:0] L_INIT   = 23'h020010;
  localparam logic [22:0] L_FETCH  = 23'h044000;
  localparam logic [22:0] L_LD_EX1 = 23'h080900;
  localparam logic [22:0] L_LD_EX2 = 23'h002200;
  localparam logic [22:0] L_JMP    = 23'h011000;
  localparam logic [22:0] L_HALT   = 23'h000001;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  control_unit_if bus();
  control_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int    n_cmp = 0;
  int    n_bad = 0;
  outs_t m_q[$];
  outs_t exp_q[$];
  string name_q[$];

  task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o = {bus.ALU_OPERATION, bus.INC_PROGCOUNT, bus.CLR_PROGCOUNT, bus.WRITE_PROGCOUNT,
         bus.READ_PROGCOUNT, bus.WRITE_INSTREG, bus.WRITE_REGS, bus.USE_IMMEDIATE,
         bus.USE_DISPLACEMENT, bus.WRITE_MEM, bus.READ_MEM, bus.WRITE_MEMADDR,
         bus.WRITE_STATREG, bus.CLR_STATBIT, bus.SET_STATBIT, bus.PRESET_STACKPTR,
         bus.INC_STACKPTR, bus.DEC_STACKPTR, bus.READ_STACKPTR, bus.HALTED};
    return o;
  endfunction

  function automatic logic inv_ok(input outs_t o);
    int reads;
    reads = int'(o.rd_mem) + int'(o.rd_sp) + int'(o.rd_pc);
    return (reads <= 1) && !(o.inc_pc && o.wr_pc) && !(o.clr_sb && o.set_sb);
  endfunction

  // Model: the list of per-cycle outputs an instruction produces, FETCH first
  function automatic void build(input logic [4:0] op, input logic [2:0] sel, input logic [7:0] st);
    outs_t o, jmp;
    logic [4:0] eop;
    m_q.delete();
    eop = op;
    if (!STK && op >= 5'd10 && op <= 5'd13) eop = 5'd0;
    o = '0; o.wr_ir = 1'b1; o.inc_pc = 1'b1; m_q.push_back(o);
    jmp = '0; jmp.use_imm = 1'b1; jmp.wr_pc = 1'b1;
    if (eop[4]) begin
      o = '0; o.alu = eop[3:0]; o.wr_regs = 1'b1; o.wr_sr = 1'b1; m_q.push_back(o);
    end else begin
      case (eop)
        5'd2: begin o = '0; o.use_imm = 1'b1; o.wr_regs = 1'b1; m_q.push_back(o); end
        5'd3, 5'd4: begin
          o = '0; o.use_disp = 1'b1; o.alu = 4'h1; o.wr_ma = 1'b1; m_q.push_back(o);
          o = '0;
          if (eop == 5'd3) begin o.rd_mem = 1'b1; o.wr_regs = 1'b1; end
          else begin o.alu = 4'h2; o.wr_mem = 1'b1; end
          m_q.push_back(o);
        end
        5'd5: m_q.push_back(jmp);
        5'd6: m_q.push_back(st[sel] ? jmp : outs_t'(0));
        5'd7: m_q.push_back(!st[sel] ? jmp : outs_t'(0));
        5'd8: begin o = '0; o.clr_sb = 1'b1; m_q.push_back(o); end
        5'd9: begin o = '0; o.set_sb = 1'b1; m_q.push_back(o); end
        5'd10: begin
          o = '0; o.rd_sp = 1'b1; o.wr_ma = 1'b1; m_q.push_back(o);
          o = '0; o.rd_pc = 1'b1; o.wr_mem = 1'b1; o.dec_sp = 1'b1; m_q.push_back(o);
          m_q.push_back(jmp);
        end
        5'd11, 5'd13: begin
          o = '0; o.inc_sp = 1'b1; m_q.push_back(o);
          o = '0; o.rd_sp = 1'b1; o.wr_ma = 1'b1; m_q.push_back(o);
          o = '0; o.rd_mem = 1'b1;
          if (eop == 5'd11) o.wr_pc = 1'b1; else o.wr_regs = 1'b1;
          m_q.push_back(o);
        end
        5'd12: begin
          o = '0; o.rd_sp = 1'b1; o.wr_ma = 1'b1; m_q.push_back(o);
          o = '0; o.alu = 4'h2; o.wr_mem = 1'b1; o.dec_sp = 1'b1; m_q.push_back(o);
        end
        default: m_q.push_back(outs_t'(0));
      endcase
    end
  endfunction

  // Compare process: one expectation per cycle, checked mid-cycle
  always @(negedge CLK) begin
    outs_t e, g;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = sample();
      chk(n, g, e);
      chk({n, "_inv"}, {22'd0, inv_ok(g)}, 23'd1);
    end
  end

  task automatic step(input string nm, input outs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input string nm, input logic [4:0] op, input logic [2:0] sel, input logic [7:0] st);
    bus.OPCODE = op; bus.STATUS_SEL = sel; bus.STATUS = st;
    build(op, sel, st);
    for (int i = 0; i < m_q.size(); i++) step($sformatf("%s_s%0d", nm, i), m_q[i]);
  endtask

  task automatic release_reset(input string nm);
    @(posedge CLK);
    #1 RESET = 1'b0;
    step({nm, "_init"}, outs_t'(L_INIT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.OPCODE = 5'd0; bus.STATUS_SEL = 3'd0; bus.STATUS = 8'h00;

    // Model pins against hand-computed vectors
    build(5'b00011, 3'd0, 8'h00);
    chk("pin_ld_len", 23'(m_q.size()), 23'd3);
    chk("pin_fetch", m_q[0], L_FETCH);
    chk("pin_ld_ex1", m_q[1], L_LD_EX1);
    chk("pin_ld_ex2", m_q[2], L_LD_EX2);
    build(5'b00110, 3'd0, 8'h01);
    chk("pin_brs_taken", m_q[1], L_JMP);
    build(5'b00110, 3'd0, 8'h00);
    chk("pin_brs_not", m_q[1], 23'h0);

    // Reset state
    #12;
    chk("reset_outputs", sample(), L_INIT);
    release_reset("boot");

    run("nop", 5'b00000, 3'd0, 8'h00);
    run("ldi", 5'b00010, 3'd0, 8'h00);
    run("ld", 5'b00011, 3'd0, 8'h00);
    run("st", 5'b00100, 3'd0, 8'h00);
    run("jmp", 5'b00101, 3'd0, 8'h00);
    run("brs_t", 5'b00110, 3'd0, 8'h01);
    run("brs_n", 5'b00110, 3'd0, 8'h00);
    run("brs_t5", 5'b00110, 3'd5, 8'h20);
    run("brc_t", 5'b00111, 3'd3, 8'h00);
    run("brc_n", 5'b00111, 3'd7, 8'h80);
    run("clrb", 5'b01000, 3'd2, 8'h00);
    run("setb", 5'b01001, 3'd2, 8'h00);
    run("alu6", 5'b10110, 3'd0, 8'h00);
    run("alu15", 5'b11111, 3'd0, 8'h00);
    run("alu0", 5'b10000, 3'd0, 8'h00);
    run("rsv14", 5'b01110, 3'd0, 8'h00);
    run("rsv15", 5'b01111, 3'd0, 8'h00);
    run("call", 5'b01010, 3'd0, 8'h00);
    run("ret", 5'b01011, 3'd0, 8'h00);
    run("push", 5'b01100, 3'd0, 8'h00);
    run("pop", 5'b01101, 3'd0, 8'h00);
    run("nop2", 5'b00000, 3'd0, 8'h00);

    // Reset in EX2 of LD
    bus.OPCODE = 5'b00011;
    build(5'b00011, 3'd0, 8'h00);
    step("ldr_s0", m_q[0]);
    step("ldr_s1", m_q[1]);
    chk("ldr_ex2", sample(), L_LD_EX2);
    #2 RESET = 1'b1;
    #1 chk("ldr_async_reset", sample(), L_INIT);
    release_reset("ldr");
    run("after_ldr", 5'b00010, 3'd0, 8'h00);

    // HALT holds, then reset out of it
    run("halt", 5'b00001, 3'd0, 8'h00);
    for (int i = 0; i < 10; i++) step($sformatf("halted_%0d", i), outs_t'(L_HALT));
    #2 RESET = 1'b1;
    #1 chk("halt_async_reset", sample(), L_INIT);
    release_reset("hlt");
    run("after_halt", 5'b00101, 3'd0, 8'h00);

    @(negedge CLK);
    chk("queue_drained", 23'(exp_q.size()), 23'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
